// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern source.
// Holds the pixel width, pattern-mode encodings, the colour-bar palette,
// the generator state type and the frame-size clamp helper.
package video_pkg;

    localparam int unsigned PIX_W = 32;

    localparam logic [2:0] MODE_SOLID   = 3'd0;
    localparam logic [2:0] MODE_HRAMP   = 3'd1;
    localparam logic [2:0] MODE_BARS    = 3'd2;
    localparam logic [2:0] MODE_CHECKER = 3'd3;
    localparam logic [2:0] MODE_SCROLL  = 3'd4;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam logic [PIX_W-1:0] BAR_PALETTE [8] = '{
        32'h00FF_FFFF, 32'h00FF_FF00, 32'h0000_FFFF, 32'h0000_FF00,
        32'h00FF_00FF, 32'h00FF_0000, 32'h0000_00FF, 32'h0000_0000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    // Zero means one; anything above the maximum saturates.
    function automatic int unsigned clamp_cfg(input int unsigned val,
                                              input int unsigned max_val);
        int unsigned res;
        if (val == 0) begin
            res = 1;
        end else if (val > max_val) begin
            res = max_val;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pattern generator for a single pixel.
// Ports:
//   mode      - pattern select (solid, h-ramp, bars, checker, scroll)
//   px, py    - pixel column / row
//   color     - solid colour
//   frame_cnt - frame count latched at frame start (scroll offset)
//   pixel_c   - resulting 0x00RRGGBB pixel
module video_pattern_pixel
    import video_pkg::*;
#(
    parameter int unsigned BAR_SHIFT = 4,
    parameter int unsigned CHK_SHIFT = 3
) (
    input  logic [2:0]       mode,
    input  logic [15:0]      px,
    input  logic [15:0]      py,
    input  logic [PIX_W-1:0] color,
    input  logic [15:0]      frame_cnt,
    output logic [PIX_W-1:0] pixel_c
);

    logic [15:0] scroll_x;
    logic [2:0]  bar_idx;
    logic        unused_bits;

    assign scroll_x    = px + frame_cnt;
    assign bar_idx     = px[BAR_SHIFT+2:BAR_SHIFT];
    assign unused_bits = ^{px[15:8], py, scroll_x[15:8]};

    // Pattern select
    always_comb begin
        pixel_c = '0;
        case (mode)
            MODE_SOLID:   pixel_c = color;
            MODE_HRAMP:   pixel_c = {8'h00, px[7:0], px[7:0], px[7:0]};
            MODE_BARS:    pixel_c = BAR_PALETTE[bar_idx];
            MODE_CHECKER: pixel_c = (px[CHK_SHIFT] ^ py[CHK_SHIFT]) ? 32'h00FF_FFFF : '0;
            MODE_SCROLL:  pixel_c = {8'h00, scroll_x[7:0], scroll_x[7:0], scroll_x[7:0]};
            default:      pixel_c = '0;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video test-pattern source with runtime frame size and mode,
// fixed horizontal/vertical blanking, frame counter and frame-done pulse.
// Ports:
//   m_axis_vid_aclk, aresetn      - clock, async active-low reset
//   enable                        - keep producing frames while high
//   cfg_mode/h_beats/v_lines/color - frame config, sampled at frame start
//   m_axis_vid_t*                 - AXI4-Stream master (tuser = SOF, tlast = EOL)
//   frame_count                   - completed frames (wraps)
//   frame_done                    - one-cycle pulse on the last handshake of a frame
//   busy                          - high whenever not idle
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned PPC         = 1,
    parameter int unsigned MAX_H_BEATS = 1024,
    parameter int unsigned MAX_V_LINES = 1024,
    parameter int unsigned H_BLANK     = 0,
    parameter int unsigned V_BLANK     = 0,
    parameter int unsigned BAR_SHIFT   = 4,
    parameter int unsigned CHK_SHIFT   = 3,
    localparam int unsigned H_W        = $clog2(MAX_H_BEATS + 1),
    localparam int unsigned V_W        = $clog2(MAX_V_LINES + 1),
    localparam int unsigned TD_W       = PIX_W * PPC
) (
    input  logic             m_axis_vid_aclk,
    input  logic             aresetn,
    input  logic             enable,
    input  logic [2:0]       cfg_mode,
    input  logic [H_W-1:0]   cfg_h_beats,
    input  logic [V_W-1:0]   cfg_v_lines,
    input  logic [31:0]      cfg_color,
    output logic [TD_W-1:0]  m_axis_vid_tdata,
    output logic             m_axis_vid_tvalid,
    input  logic             m_axis_vid_tready,
    output logic             m_axis_vid_tuser,
    output logic             m_axis_vid_tlast,
    output logic [15:0]      frame_count,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned       BLK_W     = 32;
    localparam logic [BLK_W-1:0]  HBLK_INIT = BLK_W'(H_BLANK - 1);
    localparam logic [BLK_W-1:0]  VBLK_INIT = BLK_W'(V_BLANK * (H_BLANK + 1) - 1);

    state_t            state_q, state_d;
    logic [2:0]        mode_q, mode_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic [31:0]       color_q, color_d;
    logic [15:0]       fc_lat_q, fc_lat_d;
    logic [H_W-1:0]    beat_q, beat_d;
    logic [V_W-1:0]    line_q, line_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              tvalid_q, tvalid_d;
    logic              tuser_q, tuser_d;
    logic              tlast_q, tlast_d;
    logic [15:0]       fcount_q, fcount_d;
    logic              fdone_q, fdone_d;
    logic              busy_q, busy_d;
    logic [TD_W-1:0]   tdata_q;
    logic [TD_W-1:0]   pix_bus;
    logic              load_beat;
    logic              start_frame;
    logic              frame_end;

    // Next-state, counters and next output values
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        h_d         = h_q;
        v_d         = v_q;
        color_d     = color_q;
        fc_lat_d    = fc_lat_q;
        beat_d      = beat_q;
        line_d      = line_q;
        blk_d       = blk_q;
        tvalid_d    = tvalid_q;
        tuser_d     = tuser_q;
        tlast_d     = tlast_q;
        fcount_d    = fcount_q;
        fdone_d     = 1'b0;
        load_beat   = 1'b0;
        start_frame = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (tvalid_q && m_axis_vid_tready) begin
                    if (beat_q == h_q - H_W'(1)) begin
                        if (line_q == v_q - V_W'(1)) begin
                            fcount_d = fcount_q + 16'd1;
                            fdone_d  = 1'b1;
                            tvalid_d = 1'b0;
                            tuser_d  = 1'b0;
                            tlast_d  = 1'b0;
                            if (V_BLANK > 0) begin
                                state_d = VBLANK;
                                blk_d   = VBLK_INIT;
                            end else begin
                                frame_end = 1'b1;
                            end
                        end else begin
                            beat_d = '0;
                            line_d = line_q + V_W'(1);
                            if (H_BLANK > 0) begin
                                state_d  = HBLANK;
                                blk_d    = HBLK_INIT;
                                tvalid_d = 1'b0;
                                tuser_d  = 1'b0;
                                tlast_d  = 1'b0;
                            end else begin
                                load_beat = 1'b1;
                            end
                        end
                    end else begin
                        beat_d    = beat_q + H_W'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (blk_q == '0) begin
                    state_d   = ACTIVE;
                    load_beat = 1'b1;
                end else begin
                    blk_d = blk_q - BLK_W'(1);
                end
            end
            VBLANK: begin
                if (blk_q == '0) begin
                    frame_end = 1'b1;
                end else begin
                    blk_d = blk_q - BLK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            if (enable) begin
                start_frame = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        // Latch config; the scroll offset is the count including the frame just finished
        if (start_frame) begin
            state_d   = ACTIVE;
            mode_d    = cfg_mode;
            h_d       = H_W'(clamp_cfg(32'(cfg_h_beats), MAX_H_BEATS));
            v_d       = V_W'(clamp_cfg(32'(cfg_v_lines), MAX_V_LINES));
            color_d   = cfg_color;
            fc_lat_d  = fcount_d;
            beat_d    = '0;
            line_d    = '0;
            load_beat = 1'b1;
        end

        if (load_beat) begin
            tvalid_d = 1'b1;
            tuser_d  = (beat_d == '0) && (line_d == '0);
            tlast_d  = (beat_d == h_d - H_W'(1));
        end

        busy_d = (state_d != IDLE);
    end

    // One pattern lane per pixel of the beat being loaded
    for (genvar p = 0; p < PPC; p++) begin : g_lane
        logic [15:0] px_lane;
        assign px_lane = 16'(32'(beat_d) * PPC + 32'(p));

        video_pattern_pixel #(
            .BAR_SHIFT (BAR_SHIFT),
            .CHK_SHIFT (CHK_SHIFT)
        ) u_pixel (
            .mode      (mode_d),
            .px        (px_lane),
            .py        (16'(line_d)),
            .color     (color_d),
            .frame_cnt (fc_lat_d),
            .pixel_c   (pix_bus[p*PIX_W +: PIX_W])
        );
    end

    // State, counters and output registers
    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            h_q      <= '0;
            v_q      <= '0;
            color_q  <= '0;
            fc_lat_q <= '0;
            beat_q   <= '0;
            line_q   <= '0;
            blk_q    <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            fcount_q <= '0;
            fdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            h_q      <= h_d;
            v_q      <= v_d;
            color_q  <= color_d;
            fc_lat_q <= fc_lat_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            blk_q    <= blk_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            fcount_q <= fcount_d;
            fdone_q  <= fdone_d;
            busy_q   <= busy_d;
            if (load_beat) begin
                tdata_q <= pix_bus;
            end
        end
    end

    assign m_axis_vid_tdata  = tdata_q;
    assign m_axis_vid_tvalid = tvalid_q;
    assign m_axis_vid_tuser  = tuser_q;
    assign m_axis_vid_tlast  = tlast_q;
    assign frame_count       = fcount_q;
    assign frame_done        = fdone_q;
    assign busy              = busy_q;

endmodule
